// File: rtl/squash_wb_ctrl.sv
// rtl/squash_wb_ctrl.sv - Wishbone control/status block sequencing reset, pause and frame counting for a game core (optional IRQ via SQUASH_IRQ_EN)
module squash_wb_ctrl #(
  parameter int          RST_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        gpio_ready_i,
  input  logic        frame_tick_i,
  output logic        game_reset_o,
  output logic        game_pause_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RESETTING = 2'd1,
    ST_RUNNING   = 2'd2
  } state_t;

  localparam logic [7:0] CNT_RELOAD = 8'(RST_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        run_q, run_d;
  logic        ctrl_pause_q, ctrl_pause_d;
  logic        softrst_q, softrst_d;
  logic [31:0] frames_q, frames_d;
  logic        game_reset_q, game_reset_d;
  logic        game_pause_q, game_pause_d;

  logic        access_valid;
  logic        access_start;
  logic        wr;
  logic        rd;
  logic [1:0]  off;
  logic        wr_ctrl;
  logic        wr_frames;
  logic        tick_counted;
  logic [31:0] rdata;
  logic [31:0] irq_rdata;
  logic        unused_bits;

  // A transfer is taken on its first sampled cycle only; the ack that follows blocks a second take.
  assign access_valid = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign access_start = access_valid & ~ack_q;
  assign wr           = access_start & wbs_we_i;
  assign rd           = access_start & ~wbs_we_i;
  assign off          = wbs_adr_i[3:2];
  assign wr_ctrl      = wr & (off == 2'd0) & wbs_sel_i[0];
  assign wr_frames    = wr & (off == 2'd2);
  assign tick_counted = frame_tick_i & (state_q == ST_RUNNING) & ~ctrl_pause_q;
  assign unused_bits  = ^{wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i[31:3]};

  // Read mux and bus handshake; data is only driven on the ack cycle.
  always_comb begin
    rdata = 32'd0;
    case (off)
      2'd0: rdata = {30'd0, ctrl_pause_q, run_q};
      2'd1: rdata = {29'd0, gpio_ready_i, state_q};
      2'd2: rdata = frames_q;
      2'd3: rdata = irq_rdata;
      default: rdata = 32'd0;
    endcase
    ack_d = access_valid & ~ack_q;
    dat_d = rd ? rdata : 32'd0;
  end

  // CTRL register; SOFTRST is a one-cycle pulse that never reads back.
  always_comb begin
    run_d        = run_q;
    ctrl_pause_d = ctrl_pause_q;
    softrst_d    = 1'b0;
    if (wr_ctrl) begin
      run_d        = wbs_dat_i[0];
      ctrl_pause_d = wbs_dat_i[1];
      softrst_d    = wbs_dat_i[2];
    end
  end

  // Frame counter: a bus write clears and beats a simultaneous tick.
  always_comb begin
    frames_d = frames_q;
    if (wr_frames)
      frames_d = 32'd0;
    else if (tick_counted)
      frames_d = frames_q + 32'd1;
  end

  // Sequencer next state; losing RUN or pad readiness always wins over SOFTRST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (softrst_q)
          cnt_d = CNT_RELOAD;
        if (run_q && gpio_ready_i) begin
          state_d = ST_RESETTING;
          cnt_d   = CNT_RELOAD;
        end
      end
      ST_RESETTING: begin
        if (!run_q || !gpio_ready_i)
          state_d = ST_IDLE;
        else if (softrst_q)
          cnt_d = CNT_RELOAD;
        else if (cnt_q == 8'd0)
          state_d = ST_RUNNING;
        else
          cnt_d = cnt_q - 8'd1;
      end
      ST_RUNNING: begin
        if (!run_q || !gpio_ready_i)
          state_d = ST_IDLE;
        else if (softrst_q) begin
          state_d = ST_RESETTING;
          cnt_d   = CNT_RELOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    game_reset_d = (state_d != ST_RUNNING);
    game_pause_d = ctrl_pause_d & (state_d == ST_RUNNING);
  end

  // All core state, with outputs registered from their next-state values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      ack_q        <= 1'b0;
      dat_q        <= 32'd0;
      run_q        <= 1'b0;
      ctrl_pause_q <= 1'b0;
      softrst_q    <= 1'b0;
      frames_q     <= 32'd0;
      game_reset_q <= 1'b1;
      game_pause_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      dat_q        <= dat_d;
      run_q        <= run_d;
      ctrl_pause_q <= ctrl_pause_d;
      softrst_q    <= softrst_d;
      frames_q     <= frames_d;
      game_reset_q <= game_reset_d;
      game_pause_q <= game_pause_d;
    end
  end

`ifdef SQUASH_IRQ_EN
  logic irqen_q, irqen_d;
  logic pend_q, pend_d;
  logic irq_q, irq_d;
  logic wr_irq;

  assign wr_irq    = wr & (off == 2'd3) & wbs_sel_i[0];
  assign irq_rdata = {30'd0, pend_q, irqen_q};

  // IRQ enable/pending; a counted frame sets pending even against a same-cycle clear.
  always_comb begin
    irqen_d = irqen_q;
    pend_d  = pend_q;
    if (wr_irq) begin
      irqen_d = wbs_dat_i[0];
      if (wbs_dat_i[1])
        pend_d = 1'b0;
    end
    if (tick_counted)
      pend_d = 1'b1;
    irq_d = irqen_d & pend_d;
  end

  // IRQ register state and registered interrupt line.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irqen_q <= 1'b0;
      pend_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      irqen_q <= irqen_d;
      pend_q  <= pend_d;
      irq_q   <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_rdata = 32'd0;
  assign irq_o     = 1'b0;
`endif

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign game_reset_o = game_reset_q;
  assign game_pause_o = game_pause_q;

endmodule

// File: tb/tb_squash_wb_ctrl.sv
// tb/tb_squash_wb_ctrl.sv - scoreboard bench for squash_wb_ctrl
module tb_squash_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'd0;
  logic [31:0] wdat = 32'd0;
  logic        ack;
  logic [31:0] rdat;
  logic        gpio = 1'b0;
  logic        tick = 1'b0;
  logic        game_reset;
  logic        game_pause;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  logic prev_ack = 1'b0;

`ifdef SQUASH_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  squash_wb_ctrl dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbs_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (wdat),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (rdat),
    .gpio_ready_i (gpio),
    .frame_tick_i (tick),
    .game_reset_o (game_reset),
    .game_pause_o (game_pause),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every ack, checks ack width and idle data
  always @(negedge clk) begin
    exp_t e;
    check("ack_back_to_back", {31'd0, prev_ack & ack}, 32'd0);
    if (ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack with data 0x%08h expected no ack", rdat);
      end else begin
        e = sb_q.pop_front();
        check(e.name, rdat, e.data);
      end
    end else begin
      check("dat_idle_zero", rdat, 32'd0);
    end
    prev_ack = ack;
  end

  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] exp, input string name,
                         input logic tick_with);
    exp_t e;
    logic got;
    e.data = w ? 32'd0 : exp;
    e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s; tick = tick_with;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      tick = 1'b0;
      if (ack === 1'b1) got = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no ack expected ack within 10 cycles", name);
      void'(sb_q.pop_back());
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    wb_xfer(a, 1'b0, 32'd0, 4'hF, exp, name, 1'b0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string name);
    wb_xfer(a, 1'b1, d, 4'hF, 32'd0, name, 1'b0);
  endtask

  task automatic pulse_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
    end
  endtask

  task automatic count_reset_high(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (game_reset === 1'b1) n++;
      else break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acks;
    repeat (3) @(negedge clk);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_game_reset", {31'd0, game_reset}, 32'd1);
    check("rst_game_pause", {31'd0, game_pause}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;

    rd(32'h3000_0004, 32'h0, "status_no_gpio");
    check("idle_game_reset", {31'd0, game_reset}, 32'd1);

    gpio = 1'b1;
    rd(32'h3000_0004, 32'h4, "status_gpio_idle");
    wb_xfer(32'h3000_0000, 1'b1, 32'h1, 4'hE, 32'd0, "ctrl_sel0_low", 1'b0);
    repeat (3) @(negedge clk);
    check("sel_gated_reset", {31'd0, game_reset}, 32'd1);
    rd(32'h3000_0000, 32'h0, "ctrl_after_gated");

    wr(32'h3000_0000, 32'h1, "ctrl_run");
    count_reset_high(n);
    check("reset_cycles_start", n, 32'd16);
    rd(32'h3000_0004, 32'h6, "status_running");

    pulse_ticks(5);
    wr(32'h3000_0000, 32'h3, "ctrl_pause");
    check("pause_out_on", {31'd0, game_pause}, 32'd1);
    pulse_ticks(3);
    rd(32'h3000_0008, 32'd5, "frames_five");
    wr(32'h3000_0000, 32'h1, "ctrl_unpause");
    check("pause_out_off", {31'd0, game_pause}, 32'd0);

    wr(32'h3000_0000, 32'h5, "ctrl_softrst");
    count_reset_high(n);
    check("reset_cycles_softrst", n, 32'd16);
    rd(32'h3000_0004, 32'h6, "status_running_again");
    rd(32'h3000_0008, 32'd5, "frames_after_softrst");
    rd(32'h3000_0000, 32'h1, "ctrl_softrst_reads0");

    wb_xfer(32'h3000_0008, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'd0, "frames_clear_vs_tick", 1'b1);
    rd(32'h3000_0008, 32'd0, "frames_cleared");
    pulse_ticks(2);
    rd(32'h3000_0008, 32'd2, "frames_two");
    wr(32'h3000_0004, 32'hFFFF_FFFF, "status_write_ignored");
    rd(32'h3000_0004, 32'h6, "status_unchanged");

    wr(32'h3000_000C, 32'h3, "irq_en_clear");
    check("irq_after_clear", {31'd0, irq}, 32'd0);
    pulse_ticks(1);
    check("irq_after_tick", {31'd0, irq}, {31'd0, IRQ_ON});
    rd(32'h3000_000C, IRQ_ON ? 32'h3 : 32'h0, "irq_reg_pending");
    wr(32'h3000_000C, 32'h3, "irq_ack");
    check("irq_after_ack", {31'd0, irq}, 32'd0);
    rd(32'h3000_000C, IRQ_ON ? 32'h1 : 32'h0, "irq_reg_cleared");

    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0010; sel = 4'hF;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    cyc = 1'b0; stb = 1'b0;
    check("out_of_range_acks", acks, 32'd0);

    wr(32'h3000_0000, 32'h3, "ctrl_pause_before_rst");
    check("pause_before_rst", {31'd0, game_pause}, 32'd1);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0004; sel = 4'hF;
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("midrst_ack", {31'd0, ack}, 32'd0);
    check("midrst_dat", rdat, 32'd0);
    check("midrst_game_reset", {31'd0, game_reset}, 32'd1);
    check("midrst_game_pause", {31'd0, game_pause}, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rd(32'h3000_0004, 32'h4, "status_after_midrst");
    rd(32'h3000_0008, 32'd0, "frames_after_midrst");
    repeat (4) @(negedge clk);
    check("idle_after_midrst", {31'd0, game_reset}, 32'd1);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/squash_wb_ctrl.md
SQUASH_WB_CTRL -- requirements
Module: squash_wb_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles game reset is held during a reset sequence (range 1..255).
REQ-002 Parameter BASE_ADDR, default 32'h3000_0000: Wishbone base address; registers at BASE_ADDR+0x0/0x4/0x8/0xC.
REQ-003 wb_clk_i  in  1  sole clock, all logic on rising edge.
REQ-004 wb_rst_i  in  1  asynchronous, active-high reset.
REQ-005 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic slave strobes.
REQ-006 wbs_sel_i  in  4  byte selects; wbs_adr_i  in  32  address; wbs_dat_i  in  32  write data.
REQ-007 wbs_ack_o  out  1  transfer acknowledge; wbs_dat_o  out  32  read data.
REQ-008 gpio_ready_i  in  1  level, high once pads are configured by firmware.
REQ-009 frame_tick_i  in  1  single-cycle pulse from the game at each frame start.
REQ-010 game_reset_o  out  1  reset to the game core, active high.
REQ-011 game_pause_o  out  1  freezes game state when high.
REQ-012 irq_o  out  1  level interrupt to user_irq[0].

Function
REQ-013 Decode: access valid when cyc&stb and wbs_adr_i[31:4]==BASE_ADDR[31:4]; offset wbs_adr_i[3:2].
REQ-014 wbs_ack_o SHALL pulse exactly one cycle, the cycle after a valid access is first sampled; ack never asserted two consecutive cycles; out-of-range address never acked.
REQ-015 Writes commit on the ack cycle; wbs_dat_o valid on the ack cycle, 0 otherwise.
REQ-016 CTRL (0x0): bit0 RUN, bit1 PAUSE (RW, written only if wbs_sel_i[0]); bit2 SOFTRST write-1 pulse, reads 0.
REQ-017 STATUS (0x4, RO): bits[1:0] FSM state (IDLE=0, RESETTING=1, RUNNING=2), bit2 gpio_ready_i, rest 0; writes ignored but acked.
REQ-018 FRAMES (0x8): 32-bit count of frame_tick_i while RUNNING and not paused; wraps 0xFFFF_FFFF->0; any write clears to 0, and write wins over a same-cycle tick.
REQ-019 IRQ (0xC): bit0 IRQEN (RW), bit1 PENDING (write 1 clears).
REQ-020 FSM IDLE: game_reset_o=1; go RESETTING when RUN=1 and gpio_ready_i=1.
REQ-021 FSM RESETTING: game_reset_o=1; count RST_CYCLES cycles then RUNNING; RUN=0 returns to IDLE immediately.
REQ-022 FSM RUNNING: game_reset_o=0; RUN=0 -> IDLE; SOFTRST=1 -> RESETTING with counter reloaded; RUN=0 has priority over SOFTRST.
REQ-023 SOFTRST in IDLE or RESETTING: RESETTING counter restarts; no other effect.
REQ-024 gpio_ready_i falling in RESETTING or RUNNING -> IDLE next cycle.
REQ-025 game_pause_o = PAUSE & (state==RUNNING), registered.
REQ-026 Unused offsets inside the 16-byte window: read 0, writes ignored, acked.

Reset
REQ-027 On wb_rst_i: state IDLE, counters 0, CTRL=0, IRQ=0, wbs_ack_o=0, wbs_dat_o=0, game_reset_o=1, game_pause_o=0, irq_o=0.
REQ-028 Reset mid-transfer aborts the access without ack; the master retries.

Configuration
REQ-029 Macro SQUASH_IRQ_EN defined: PENDING set on each counted frame_tick_i, irq_o=IRQEN&PENDING; set wins over same-cycle clear.
REQ-030 SQUASH_IRQ_EN undefined: IRQ register reads 0, writes acked and ignored, irq_o tied 0, no IRQ flops.

Verification
REQ-031 Reset, read 0x3000_0004 -> ack 1 cycle later, data 0x0 (gpio_ready_i=0), game_reset_o=1.
REQ-032 gpio_ready_i=1, write CTRL=0x1 -> game_reset_o high exactly 16 cycles after RESETTING entry, STATUS reads 0x6.
REQ-033 RUNNING, 5 frame_tick_i pulses, then PAUSE=1 plus 3 pulses -> FRAMES reads 5, game_pause_o=1.
REQ-034 RUNNING, write CTRL=0x5 -> RESETTING, game_reset_o=1 for 16 cycles, RUNNING again; FRAMES unchanged.
REQ-035 SQUASH_IRQ_EN, IRQEN=1, one tick -> irq_o=1; write IRQ=0x3 -> irq_o=0; without macro irq_o stays 0.
REQ-036 Access at 0x3000_0010 -> no ack for 8 cycles; wb_rst_i pulse mid-RUNNING -> IDLE, all outputs at reset values.
